// File: rtl/exp6_unidade_controle.sv
// Moore control unit for the exp6 multi-round memory game.
// Optional inactivity timeout is enabled with the EXP6_TIMEOUT_EN macro.
module exp6_unidade_controle #(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TW             = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  estado_t    state_q, state_d;
  logic       zera_e_q, zera_e_d;
  logic       conta_e_q, conta_e_d;
  logic       zera_l_q, zera_l_d;
  logic       conta_l_q, conta_l_d;
  logic       zera_r_q, zera_r_d;
  logic       registra_r_q, registra_r_d;
  logic       acertou_q, acertou_d;
  logic       errou_q, errou_d;
  logic       timeout_q, timeout_d;
  logic       pronto_q, pronto_d;
  logic [3:0] db_estado_q, db_estado_d;

`ifdef EXP6_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tmo_hit;
`endif

  always_comb begin
    state_d = state_q;
`ifdef EXP6_TIMEOUT_EN
    tmo_hit = (cnt_q == TW'(TIMEOUT_CICLOS - 1));
    // Counter only runs while waiting for a play and saturates at all ones.
    cnt_d = '0;
    if (state_q == ESPERA) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TW'(1);
    end
`endif

    case (state_q)
      INICIAL:        if (iniciar) state_d = PREPARACAO;
      PREPARACAO:     state_d = INICIA_RODADA;
      INICIA_RODADA:  state_d = ESPERA;
      ESPERA: begin
        if (jogada) begin
          state_d = REGISTRA;
        end
`ifdef EXP6_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = FIM_TIMEOUT;
        end
`endif
      end
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     state_d = FIM_ERRO;
        else if (!fimE) state_d = PROXIMA_JOGADA;
        else if (fimL)  state_d = FIM_ACERTO;
        else            state_d = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: state_d = ESPERA;
      PROXIMA_RODADA: state_d = INICIA_RODADA;
      FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: if (iniciar) state_d = PREPARACAO;
      default:        state_d = INICIAL;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    zera_e_d     = (state_d == INICIAL) || (state_d == PREPARACAO) || (state_d == INICIA_RODADA);
    zera_l_d     = (state_d == INICIAL) || (state_d == PREPARACAO);
    zera_r_d     = (state_d == INICIAL) || (state_d == PREPARACAO);
    registra_r_d = (state_d == REGISTRA);
    conta_e_d    = (state_d == PROXIMA_JOGADA);
    conta_l_d    = (state_d == PROXIMA_RODADA);
    acertou_d    = (state_d == FIM_ACERTO);
    errou_d      = (state_d == FIM_ERRO);
`ifdef EXP6_TIMEOUT_EN
    timeout_d    = (state_d == FIM_TIMEOUT);
`else
    timeout_d    = 1'b0;
`endif
    pronto_d     = (state_d == FIM_ACERTO) || (state_d == FIM_ERRO) || (state_d == FIM_TIMEOUT);

    case (state_d)
      INICIAL, PREPARACAO, INICIA_RODADA, ESPERA, REGISTRA, COMPARACAO,
      PROXIMA_JOGADA, PROXIMA_RODADA, FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO:
        db_estado_d = state_d;
      default: db_estado_d = 4'hF;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= INICIAL;
      zera_e_q     <= 1'b1;
      conta_e_q    <= 1'b0;
      zera_l_q     <= 1'b1;
      conta_l_q    <= 1'b0;
      zera_r_q     <= 1'b1;
      registra_r_q <= 1'b0;
      acertou_q    <= 1'b0;
      errou_q      <= 1'b0;
      timeout_q    <= 1'b0;
      pronto_q     <= 1'b0;
      db_estado_q  <= 4'h0;
`ifdef EXP6_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      zera_e_q     <= zera_e_d;
      conta_e_q    <= conta_e_d;
      zera_l_q     <= zera_l_d;
      conta_l_q    <= conta_l_d;
      zera_r_q     <= zera_r_d;
      registra_r_q <= registra_r_d;
      acertou_q    <= acertou_d;
      errou_q      <= errou_d;
      timeout_q    <= timeout_d;
      pronto_q     <= pronto_d;
      db_estado_q  <= db_estado_d;
`ifdef EXP6_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign zeraE     = zera_e_q;
  assign contaE    = conta_e_q;
  assign zeraL     = zera_l_q;
  assign contaL    = conta_l_q;
  assign zeraR     = zera_r_q;
  assign registraR = registra_r_q;
  assign acertou   = acertou_q;
  assign errou     = errou_q;
  assign timeout   = timeout_q;
  assign pronto    = pronto_q;
  assign db_estado = db_estado_q;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Randomized game-level bench for exp6_unidade_controle.
module tb_exp6_unidade_controle;

  localparam int TMO = 8;
`ifdef EXP6_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, iniciar, jogada, igual, fimE, fimL;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  exp6_unidade_controle #(.TIMEOUT_CICLOS(TMO), .TW(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .acertou(acertou), .errou(errou),
    .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] outs();
    return {zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto};
  endfunction

  // Expected output vector for a displayed state code, taken from the output table.
  function automatic logic [9:0] expectOutputs(input logic [3:0] code);
    logic ze, ce, zl, cl, zr, rr, ac, er, to, pr;
    ze = (code == 4'h0) || (code == 4'h1) || (code == 4'h2);
    zl = (code == 4'h0) || (code == 4'h1);
    zr = zl;
    rr = (code == 4'h4);
    ce = (code == 4'h6);
    cl = (code == 4'h7);
    ac = (code == 4'hA);
    er = (code == 4'hE);
    to = (code == 4'hD);
    pr = ac || er || to;
    return {ze, ce, zl, cl, zr, rr, ac, er, to, pr};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] code);
    @(posedge clock);
    #1;
    checkOutput(tag, {12'h0, db_estado}, {12'h0, code});
    checkOutput({tag, "_outs"}, {6'h0, outs()}, {6'h0, expectOutputs(code)});
  endtask

  task automatic restartGame(input string tag);
    iniciar = 1'b1;
    applyStimulus({tag, "_prep"}, 4'h1);
    iniciar = 1'b0;
    applyStimulus({tag, "_ini"}, 4'h2);
    applyStimulus({tag, "_esp"}, 4'h3);
  endtask

  // Plays one game: rounds 0..last_k, round k repeats positions 0..k; one play may be wrong.
  task automatic playGame(input int g);
    int last_k, n_plays, err_play, play_idx, idle;
    bit ended, correct;
    logic [3:0] final_code;
    last_k = (g == 0) ? 2 : $urandom_range(0, 2);
    n_plays = (last_k + 1) * (last_k + 2) / 2;
    if (g == 0) err_play = -1;
    else if (g == 1 || $urandom_range(0, 1) == 1) err_play = $urandom_range(0, n_plays - 1);
    else err_play = -1;
    play_idx = 0;
    ended = 1'b0;
    final_code = 4'hA;
    for (int k = 0; k <= last_k; k++) begin
      for (int e = 0; e <= k; e++) begin
        if (!ended) begin
          idle = $urandom_range(0, TMO - 2);
          repeat (idle) begin
            iniciar = 1'($urandom_range(0, 1));
            applyStimulus("wait", 4'h3);
          end
          iniciar = 1'b0;
          correct = (play_idx != err_play);
          igual = correct;
          fimE = (e == k);
          fimL = (k == last_k);
          jogada = 1'b1;
          applyStimulus("registra", 4'h4);
          jogada = 1'b0;
          applyStimulus("comparacao", 4'h5);
          if (!correct) begin
            applyStimulus("fim_erro", 4'hE);
            final_code = 4'hE;
            ended = 1'b1;
          end else if (e < k) begin
            applyStimulus("prox_jogada", 4'h6);
            applyStimulus("volta_espera", 4'h3);
          end else if (k == last_k) begin
            applyStimulus("fim_acerto", 4'hA);
            ended = 1'b1;
          end else begin
            applyStimulus("prox_rodada", 4'h7);
            applyStimulus("nova_rodada", 4'h2);
            applyStimulus("espera_rodada", 4'h3);
          end
          play_idx++;
        end
      end
    end
    igual = 1'b0;
    repeat (2) begin
      jogada = 1'b1;
      applyStimulus("fim_ignora_jogada", final_code);
    end
    jogada = 1'b0;
    applyStimulus("fim_hold", final_code);
    restartGame("restart");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimE = 1'b0; fimL = 1'b0;
    #12;
    checkOutput("reset_state", {12'h0, db_estado}, 16'h0);
    checkOutput("reset_outs", {6'h0, outs()}, {6'h0, expectOutputs(4'h0)});
    reset = 1'b1;
    applyStimulus("idle_inicial", 4'h0);
    jogada = 1'b1;
    applyStimulus("inicial_ignora_jogada", 4'h0);
    jogada = 1'b0;
    restartGame("start");

    for (int g = 0; g < 8; g++) playGame(g);

    // Inactivity: the 8th cycle in espera leaves for fim_timeout when enabled.
    repeat (TMO - 1) applyStimulus("to_wait", 4'h3);
    applyStimulus("to_hit", TO_EN ? 4'hD : 4'h3);
    if (TO_EN) begin
      jogada = 1'b1;
      applyStimulus("to_ignora_jogada", 4'hD);
      jogada = 1'b0;
      restartGame("to_restart");
    end else begin
      repeat (100 - TMO - 1) begin
        @(posedge clock);
        #1;
      end
      applyStimulus("no_timeout_100", 4'h3);
    end

    // A play on the last allowed cycle wins over the timeout.
    repeat (TMO - 1) applyStimulus("last_wait", 4'h3);
    jogada = 1'b1; igual = 1'b1; fimE = 1'b0; fimL = 1'b0;
    applyStimulus("late_jogada", 4'h4);
    jogada = 1'b0;
    applyStimulus("late_cmp", 4'h5);
    applyStimulus("late_next", 4'h6);
    applyStimulus("late_back", 4'h3);

    // Asynchronous reset in the middle of comparacao.
    jogada = 1'b1;
    applyStimulus("pre_rst_reg", 4'h4);
    jogada = 1'b0;
    applyStimulus("pre_rst_cmp", 4'h5);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_state", {12'h0, db_estado}, 16'h0);
    checkOutput("async_reset_outs", {6'h0, outs()}, {6'h0, expectOutputs(4'h0)});
    #1 reset = 1'b1;
    applyStimulus("after_reset", 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
